tile_map_walker: RTL and testbench

//  Upstream sequencer for the per-tile renderer. Walks a MAP_COLS x MAP_ROWS tile map in

---
 rtl/gfx_pkg.sv | 29 ++
 rtl/tile_cursor.sv | 62 ++++++
 rtl/tile_map_walker.sv | 124 ++++++++++++
 tb/tb_tile_map_walker.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared graphics constants and the tile walker state encoding.
// Screen geometry drives the default map and tile dimensions.
package gfx_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int TILE_W      = 32;
  localparam int TILE_H      = 32;
  localparam int MAP_COLS    = SCREEN_W / TILE_W;
  localparam int MAP_ROWS    = SCREEN_H / TILE_H;
  localparam int TILE_WORDS  = 1024;
  localparam int TILE_CYCLES = 1027;
  localparam int MAP_AW      = 9;
  localparam int TADDR_W     = 19;
  localparam int POS_W       = 10;

  localparam logic [7:0] EMPTY_IDX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    ISSUE,
    RENDER,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/tile_cursor.sv
// Raster cursor over the tile map: cell address and pixel origin
// kept as step accumulators, so no multipliers are needed.
module tile_cursor
  import gfx_pkg::*;
#(
  parameter int COLS   = MAP_COLS,
  parameter int ROWS   = MAP_ROWS,
  parameter int STEP_X = TILE_W,
  parameter int STEP_Y = TILE_H,
  parameter int AW     = MAP_AW,
  parameter int PW     = POS_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          clear,
  output logic [AW-1:0] addr,
  output logic [PW-1:0] top,
  output logic [PW-1:0] left,
  output logic          last
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_end;
  logic          row_end;

  assign col_end = (col == CW'(COLS - 1));
  assign row_end = (row == RW'(ROWS - 1));
  assign last    = col_end && row_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
      top  <= '0;
      left <= '0;
    end else if (clear || (step && last)) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
      top  <= '0;
      left <= '0;
    end else if (step) begin
      addr <= addr + AW'(1);
      if (col_end) begin
        col  <= '0;
        left <= '0;
        row  <= row + RW'(1);
        top  <= top + PW'(STEP_Y);
      end else begin
        col  <= col + CW'(1);
        left <= left + PW'(STEP_X);
      end
    end
  end

endmodule

// File: rtl/tile_map_walker.sv
// Walks the tile map in raster order and hands each non-empty
// tile to the renderer, holding its origin while it is drawn.
module tile_map_walker #(
  parameter int          MAP_COLS    = gfx_pkg::MAP_COLS,
  parameter int          MAP_ROWS    = gfx_pkg::MAP_ROWS,
  parameter int          TILE_W      = gfx_pkg::TILE_W,
  parameter int          TILE_H      = gfx_pkg::TILE_H,
  parameter int          TILE_WORDS  = gfx_pkg::TILE_WORDS,
  parameter int          TILE_CYCLES = gfx_pkg::TILE_CYCLES,
  parameter logic [7:0]  EMPTY_IDX   = gfx_pkg::EMPTY_IDX,
  parameter int          MAP_AW      = gfx_pkg::MAP_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [MAP_AW-1:0] map_addr,
  input  logic [7:0]        map_data,
  output logic [18:0]       tile_addr,
  output logic [9:0]        top,
  output logic [9:0]        left,
  output logic              tile_go,
  output logic              busy,
  output logic              frame_done
);

  import gfx_pkg::*;

  localparam int CNT_W = (TILE_CYCLES > 1) ? $clog2(TILE_CYCLES) : 1;
  localparam int SHIFT = $clog2(TILE_WORDS);

  state_t         state;
  logic [CNT_W-1:0] cnt;
  logic           hit;
  logic           step;
  logic           clear;
  logic           last;
  logic [9:0]     cur_top;
  logic [9:0]     cur_left;

  assign step  = (state == NEXT) && !last;
  assign clear = (state == DONE);

  tile_cursor #(
    .COLS   (MAP_COLS),
    .ROWS   (MAP_ROWS),
    .STEP_X (TILE_W),
    .STEP_Y (TILE_H),
    .AW     (MAP_AW),
    .PW     (10)
  ) u_cursor (
    .clk   (clk),
    .rst   (rst),
    .step  (step),
    .clear (clear),
    .addr  (map_addr),
    .top   (cur_top),
    .left  (cur_left),
    .last  (last)
  );

  // ROM data lands during WAIT, so the tile is latched on the WAIT->ISSUE
  // edge and every output is already valid in the ISSUE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hit        <= 1'b0;
      tile_addr  <= '0;
      top        <= '0;
      left       <= '0;
      tile_go    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tile_go    <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          state <= WAIT;
        end
        WAIT: begin
          state <= ISSUE;
          hit   <= (map_data != EMPTY_IDX);
          if (map_data != EMPTY_IDX) begin
            tile_addr <= 19'(map_data) << SHIFT;
            top       <= cur_top;
            left      <= cur_left;
            tile_go   <= 1'b1;
            cnt       <= CNT_W'(TILE_CYCLES - 1);
          end
        end
        ISSUE: begin
          state <= hit ? RENDER : NEXT;
        end
        RENDER: begin
          if (cnt == '0) state <= NEXT;
          else cnt <= cnt - CNT_W'(1);
        end
        NEXT: begin
          if (last) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_map_walker.sv
// Directed bench for tile_map_walker with a sync map ROM model and
// a downstream renderer model checking framebuffer write addresses.
module tb_tile_map_walker;

  localparam int TC    = 35;
  localparam int PIX   = 32;
  localparam int COLS  = 20;
  localparam int ROWS  = 15;
  localparam int NCELL = COLS * ROWS;
  localparam int PER   = TC + 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  map_addr;
  logic [7:0]  map_data;
  logic [18:0] tile_addr;
  logic [9:0]  top;
  logic [9:0]  left;
  logic        tile_go;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  tile_map_walker #(.TILE_CYCLES(TC)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .map_addr   (map_addr),
    .map_data   (map_data),
    .tile_addr  (tile_addr),
    .top        (top),
    .left       (left),
    .tile_go    (tile_go),
    .busy       (busy),
    .frame_done (frame_done)
  );

  logic [7:0] rom [512];

  always @(posedge clk) map_data <= rom[map_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int go_n   = 0;
  int fd_n   = 0;
  int sb_err = 0;
  int sb_wr  = 0;
  int go_top  [2048];
  int go_left [2048];
  int go_cyc  [2048];
  logic rd_on = 1'b0;
  int rd_p    = 0;
  int rd_top  = 0;
  int rd_left = 0;

  function automatic int fb_addr(int t, int l, int p);
    return (t + p / 32) * 640 + l + p % 32;
  endfunction

  // Renderer model: one framebuffer write per cycle after tile_go,
  // addressed from whatever top/left the walker is presenting.
  always @(negedge clk) begin
    if (rst) begin
      rd_on <= 1'b0;
    end else begin
      if (rd_on) begin
        if (fb_addr(int'(top), int'(left), rd_p) != fb_addr(rd_top, rd_left, rd_p))
          sb_err <= sb_err + 1;
        sb_wr <= sb_wr + 1;
        rd_p  <= rd_p + 1;
        if (rd_p == PIX - 1) rd_on <= 1'b0;
      end
      if (tile_go) begin
        go_top[go_n]  <= int'(top);
        go_left[go_n] <= int'(left);
        go_cyc[go_n]  <= cyc;
        go_n          <= go_n + 1;
        rd_on         <= 1'b1;
        rd_p          <= 0;
        rd_top        <= int'(top);
        rd_left       <= int'(left);
      end
      if (frame_done) fd_n <= fd_n + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int st_cyc = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("%s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start  = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill(input int lo, input int hi, input logic [7:0] v);
    for (int i = lo; i <= hi; i++) rom[i] = v;
  endtask

  task automatic wait_go(input string tag, input int max);
    int ok;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tile_go) begin
        ok = 1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  task automatic wait_fd(input string tag, input int max);
    int ok;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  task automatic check_frame(input string tag, input int base);
    int k;
    int bad;
    k   = base;
    bad = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (rom[r * COLS + c] != 8'hFF) begin
          if (go_top[k] != r * 32 || go_left[k] != c * 32) bad++;
          k++;
        end
      end
    end
    check({tag, "_pos"}, bad, 0);
    check({tag, "_cnt"}, go_n - base, k - base);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_map_addr"}, int'(map_addr), 0);
    check({tag, "_tile_addr"}, int'(tile_addr), 0);
    check({tag, "_top"}, int'(top), 0);
    check({tag, "_left"}, int'(left), 0);
    check({tag, "_tile_go"}, int'(tile_go), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  initial begin
    int base;
    int fbase;
    int wbase;
    int hold;
    rst   = 1'b1;
    start = 1'b0;
    fill(0, 511, 8'h00);
    tick(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    tick(2);

    // 1: every cell index 0
    base  = go_n;
    fbase = fd_n;
    wbase = sb_wr;
    pulse_start();
    wait_go("t1_go_timeout", 10);
    check("t1_latency", cyc - st_cyc, 3);
    check("t1_busy", int'(busy), 1);
    check("t1_tile_addr", int'(tile_addr), 0);
    wait_fd("t1_fd_timeout", 20000);
    check("t1_frame_len", cyc - st_cyc, NCELL * PER + 1);
    check("t1_busy_at_fd", int'(busy), 1);
    @(negedge clk);
    check("t1_busy_after", int'(busy), 0);
    check("t1_fd_width", int'(frame_done), 0);
    tick(2);
    check("t1_first_top", go_top[base], 0);
    check("t1_first_left", go_left[base], 0);
    check("t1_second_left", go_left[base + 1], 32);
    check("t1_21st_top", go_top[base + 20], 32);
    check("t1_21st_left", go_left[base + 20], 0);
    check("t1_last_top", go_top[base + 299], 448);
    check("t1_last_left", go_left[base + 299], 608);
    check("t1_go_spacing", go_cyc[base + 1] - go_cyc[base], PER);
    check_frame("t1", base);
    check("t1_fd_count", fd_n - fbase, 1);
    check("t1_fb_writes", sb_wr - wbase, NCELL * PIX);
    check("t1_fb_addr_err", sb_err, 0);

    // 2: only cell 0 holds a tile, index 5
    fill(0, 511, 8'hFF);
    rom[0] = 8'd5;
    base  = go_n;
    pulse_start();
    wait_go("t2_go_timeout", 10);
    check("t2_tile_addr", int'(tile_addr), 5120);
    check("t2_top", int'(top), 0);
    check("t2_left", int'(left), 0);
    @(negedge clk);
    check("t2_go_width", int'(tile_go), 0);
    hold = 0;
    for (int i = 0; i < TC; i++) begin
      if (tile_addr != 19'd5120 || top != 10'd0 || left != 10'd0 || tile_go) hold++;
      @(negedge clk);
    end
    check("t2_hold", hold, 0);
    wait_fd("t2_fd_timeout", 5000);
    check("t2_frame_len", cyc - st_cyc, PER + (NCELL - 1) * 4 + 1);
    tick(2);
    check("t2_go_count", go_n - base, 1);

    // 3: first row transparent, remainder index 1
    fill(0, 511, 8'd1);
    fill(0, 19, 8'hFF);
    base = go_n;
    pulse_start();
    wait_go("t3_go_timeout", 200);
    check("t3_latency", cyc - st_cyc, 83);
    check("t3_top", int'(top), 32);
    check("t3_left", int'(left), 0);
    check("t3_tile_addr", int'(tile_addr), 1024);
    wait_fd("t3_fd_timeout", 20000);
    check("t3_frame_len", cyc - st_cyc, 80 + 280 * PER + 1);
    tick(2);
    check_frame("t3", base);

    // 4: stray start pulses mid-frame and on frame_done
    fill(0, 511, 8'h00);
    base  = go_n;
    fbase = fd_n;
    pulse_start();
    hold = st_cyc;
    tick(500);
    check("t4_busy_mid", int'(busy), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_fd("t4_fd_timeout", 20000);
    check("t4_frame_len", cyc - hold, NCELL * PER + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_busy_fall", int'(busy), 0);
    tick(20);
    check("t4_no_restart", int'(busy), 0);
    check("t4_go_count", go_n - base, NCELL);
    check("t4_fd_count", fd_n - fbase, 1);

    // 5: reset during render of tile 7
    base  = go_n;
    fbase = fd_n;
    pulse_start();
    for (int i = 0; i < 7; i++) wait_go("t5_go_timeout", 100);
    tick(10);
    check("t5_pre_left", int'(left), 192);
    #1 rst = 1'b1;
    #1 check_idle_outputs("t5_abort");
    tick(2);
    rst = 1'b0;
    tick(50);
    check("t5_no_fd", fd_n - fbase, 0);
    check("t5_go_count", go_n - base, 7);
    rom[0] = 8'd3;
    pulse_start();
    wait_go("t5_go2_timeout", 10);
    check("t5_restart_latency", cyc - st_cyc, 3);
    check("t5_restart_top", int'(top), 0);
    check("t5_restart_left", int'(left), 0);
    check("t5_restart_addr", int'(tile_addr), 3072);
    tick(5);
    check("t5_fb_addr_err", sb_err, 0);
    rst = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
